// File: rtl/ninjin_ddr_sched.sv
// ----------------------------------------------------------------------------
// ninjin_ddr_sched
//
// Splits host-memory transfer jobs into DDR bursts and hands them to an AXI
// master one at a time. There are two independent job ports: read
// (host -> on-chip RAM) and write (on-chip RAM -> host). Bursts from the two
// ports are interleaved round-robin, one burst per grant.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   rd_req/rd_base/rd_total        read-job request pulse, byte base, words
//   wr_req/wr_base/wr_total        write-job request pulse, byte base, words
//   rd_busy/rd_done/rd_err         read-job status (busy, done pulse, sticky err)
//   wr_busy/wr_done/wr_err         write-job status
//   ddr_req                        one-cycle burst request to the AXI master
//   ddr_mode/ddr_base/ddr_len      burst descriptor, held until the burst ends
//   ddr_done/ddr_err               burst completion pulse and error code
// ----------------------------------------------------------------------------
module ninjin_ddr_sched #(
  parameter  int BURST_MAX = 256,
  parameter  int BWIDTH    = 32,
  parameter  int WORDSIZE  = 12,
  parameter  int LWIDTH    = 9,
  parameter  int TWIDTH    = 20,
  // Byte-offset bits of one bus word; equals clogb2(BWIDTH/8-1) for the
  // power-of-two bus widths this block supports.
  localparam int LSB       = $clog2(BWIDTH / 8),
  localparam int AWIDTH    = WORDSIZE + LSB
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              rd_req,
  input  logic [AWIDTH-1:0] rd_base,
  input  logic [TWIDTH-1:0] rd_total,
  input  logic              wr_req,
  input  logic [AWIDTH-1:0] wr_base,
  input  logic [TWIDTH-1:0] wr_total,

  output logic              rd_busy,
  output logic              wr_busy,
  output logic              rd_done,
  output logic              wr_done,
  output logic              rd_err,
  output logic              wr_err,

  output logic              ddr_req,
  output logic              ddr_mode,
  output logic [AWIDTH-1:0] ddr_base,
  output logic [LWIDTH-1:0] ddr_len,
  input  logic              ddr_done,
  input  logic [3:0]        ddr_err
);

  // Port index doubles as the DDR mode bit: 0 = read, 1 = write.
  localparam logic DDR_READ  = 1'b0;
  localparam logic DDR_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT
  } state_t;

  // Request inputs gathered into per-port vectors (index 0 = read, 1 = write).
  logic [1:0]             req_in;
  logic [1:0][AWIDTH-1:0] base_in;
  logic [1:0][TWIDTH-1:0] total_in;

  assign req_in   = {wr_req, rd_req};
  assign base_in  = {wr_base, rd_base};
  assign total_in = {wr_total, rd_total};

  // Only bit 0 of the master error code matters here.
  logic unused_err_bits;
  assign unused_err_bits = ^ddr_err[3:1];

  state_t                 state_q, state_d;
  logic                   prio_q, prio_d;       // port that wins a contended grant
  logic                   ddr_mode_q, ddr_mode_d;
  logic [AWIDTH-1:0]      ddr_base_q, ddr_base_d;
  logic [LWIDTH-1:0]      ddr_len_q, ddr_len_d;
  logic                   fail_q, fail_d;       // ddr_err[0] captured on ddr_done

  logic [1:0][AWIDTH-1:0] cur_base_q, cur_base_d;
  logic [1:0][TWIDTH-1:0] remain_q, remain_d;
  logic [1:0]             busy_q, busy_d;
  logic [1:0]             err_q, err_d;
  logic [1:0]             done_q, done_d;

  logic [1:0]             pending;
  logic                   grant;
  logic [TWIDTH-1:0]      grant_remain;

  assign pending[0] = (remain_q[0] != '0);
  assign pending[1] = (remain_q[1] != '0);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    ddr_mode_d = ddr_mode_q;
    ddr_base_d = ddr_base_q;
    ddr_len_d  = ddr_len_q;
    fail_d     = fail_q;
    cur_base_d = cur_base_q;
    remain_d   = remain_q;
    busy_d     = busy_q;
    err_d      = err_q;
    done_d     = '0;

    // A lone pending port always wins; with both pending the priority holder
    // wins, and priority then passes to the other port.
    case (pending)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = prio_q;
    endcase
    grant_remain = remain_q[grant];

    case (state_q)
      S_IDLE: begin
        if (|pending) begin
          ddr_mode_d = grant ? DDR_WRITE : DDR_READ;
          ddr_base_d = cur_base_q[grant];
          ddr_len_d  = (grant_remain > TWIDTH'(BURST_MAX)) ? LWIDTH'(BURST_MAX)
                                                            : grant_remain[LWIDTH-1:0];
          prio_d     = ~grant;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        if (ddr_done) begin
          fail_d  = ddr_err[0];
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        state_d = S_IDLE;
        if (fail_q) begin
          // A failed burst abandons the rest of the job.
          remain_d[ddr_mode_q] = '0;
          err_d[ddr_mode_q]    = 1'b1;
          done_d[ddr_mode_q]   = 1'b1;
          busy_d[ddr_mode_q]   = 1'b0;
        end else begin
          remain_d[ddr_mode_q]   = remain_q[ddr_mode_q] - TWIDTH'(ddr_len_q);
          // Byte address wraps at the address width; no 4 KB splitting.
          cur_base_d[ddr_mode_q] = cur_base_q[ddr_mode_q] + (AWIDTH'(ddr_len_q) << LSB);
          if (remain_q[ddr_mode_q] == TWIDTH'(ddr_len_q)) begin
            done_d[ddr_mode_q] = 1'b1;
            busy_d[ddr_mode_q] = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Job acceptance. A port in its done cycle still counts as busy, so a
    // request coinciding with the done pulse is dropped. The burst engine only
    // ever updates a busy port, so it never collides with an acceptance here.
    for (int p = 0; p < 2; p++) begin
      if (req_in[p] && !busy_q[p] && !done_q[p]) begin
        cur_base_d[p] = base_in[p];
        remain_d[p]   = total_in[p];
        err_d[p]      = 1'b0;
        // Zero-length job: complete immediately without touching the DDR.
        busy_d[p]     = (total_in[p] != '0);
        done_d[p]     = (total_in[p] == '0);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prio_q     <= DDR_READ;
      ddr_mode_q <= DDR_READ;
      ddr_base_q <= '0;
      ddr_len_q  <= '0;
      fail_q     <= 1'b0;
      cur_base_q <= '0;
      remain_q   <= '0;
      busy_q     <= '0;
      err_q      <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      ddr_mode_q <= ddr_mode_d;
      ddr_base_q <= ddr_base_d;
      ddr_len_q  <= ddr_len_d;
      fail_q     <= fail_d;
      cur_base_q <= cur_base_d;
      remain_q   <= remain_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign ddr_req  = (state_q == S_ISSUE);
  assign ddr_mode = ddr_mode_q;
  assign ddr_base = ddr_base_q;
  assign ddr_len  = ddr_len_q;

  assign rd_busy  = busy_q[0];
  assign wr_busy  = busy_q[1];
  assign rd_done  = done_q[0];
  assign wr_done  = done_q[1];
  assign rd_err   = err_q[0];
  assign wr_err   = err_q[1];

endmodule

// File: tb/tb_ninjin_ddr_sched.sv
// ----------------------------------------------------------------------------
// tb_ninjin_ddr_sched
//
// Directed bench for ninjin_ddr_sched with default parameters (BURST_MAX=256,
// BWIDTH=32 -> 14-bit byte addresses). Expected bursts are queued when a job
// is launched and compared when the scheduler raises ddr_req; the bench then
// plays the AXI master and returns ddr_done.
// ----------------------------------------------------------------------------
module tb_ninjin_ddr_sched;

  localparam int AW = 14;
  localparam int LW = 9;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [TW-1:0] rd_total = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_base = '0;
  logic [TW-1:0] wr_total = '0;
  logic          rd_busy, wr_busy, rd_done, wr_done, rd_err, wr_err;
  logic          ddr_req, ddr_mode;
  logic [AW-1:0] ddr_base;
  logic [LW-1:0] ddr_len;
  logic          ddr_done = 1'b0;
  logic [3:0]    ddr_err = '0;

  ninjin_ddr_sched dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_base  (rd_base),
    .rd_total (rd_total),
    .wr_req   (wr_req),
    .wr_base  (wr_base),
    .wr_total (wr_total),
    .rd_busy  (rd_busy),
    .wr_busy  (wr_busy),
    .rd_done  (rd_done),
    .wr_done  (wr_done),
    .rd_err   (rd_err),
    .wr_err   (wr_err),
    .ddr_req  (ddr_req),
    .ddr_mode (ddr_mode),
    .ddr_base (ddr_base),
    .ddr_len  (ddr_len),
    .ddr_done (ddr_done),
    .ddr_err  (ddr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
  } burst_t;

  burst_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitors on the falling edge, away from the active edge.
  int req_cnt = 0, rd_done_cnt = 0, wr_done_cnt = 0;
  int since_req = 100;

  always @(negedge clk) begin
    if (rd_done) rd_done_cnt++;
    if (wr_done) wr_done_cnt++;
    if (rst) begin
      since_req = 100;
    end else if (ddr_req) begin
      req_cnt++;
      // At least two low cycles between request pulses.
      check("ddr_req_gap", 32'(since_req >= 2), 32'd1);
      since_req = 0;
    end else begin
      since_req++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic mode, input logic [AW-1:0] base, input logic [LW-1:0] len);
    burst_t b;
    b.mode = mode;
    b.base = base;
    b.len  = len;
    exp_q.push_back(b);
  endtask

  // Waits for the next ddr_req and checks it against the scoreboard head.
  task automatic expect_burst();
    int waited = 0;
    burst_t b;
    while (ddr_req !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check("burst_issued", 32'(ddr_req), 32'd1);
    if (ddr_req === 1'b1) begin
      check("burst_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("burst_mode", 32'(ddr_mode), 32'(b.mode));
        check("burst_base", 32'(ddr_base), 32'(b.base));
        check("burst_len",  32'(ddr_len),  32'(b.len));
        tick();
        check("req_single_cycle", 32'(ddr_req), 32'd0);
        tick();
        check("len_held", 32'(ddr_len), 32'(b.len));
      end
    end
  endtask

  // Master response: ddr_done pulse with the given error code.
  task automatic finish_burst(input logic [3:0] err);
    tick();
    ddr_done = 1'b1;
    ddr_err  = err;
    tick();
    ddr_done = 1'b0;
    ddr_err  = '0;
  endtask

  task automatic serve(input logic [3:0] err);
    expect_burst();
    finish_burst(err);
  endtask

  int req0, rd0, wr0;

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_ddr_req",  32'(ddr_req),  32'd0);
    check("rst_ddr_mode", 32'(ddr_mode), 32'd0);
    check("rst_ddr_base", 32'(ddr_base), 32'd0);
    check("rst_ddr_len",  32'(ddr_len),  32'd0);
    check("rst_busy",     32'({rd_busy, wr_busy}), 32'd0);
    check("rst_done",     32'({rd_done, wr_done}), 32'd0);
    check("rst_err",      32'({rd_err, wr_err}),   32'd0);
    rst = 1'b0;
    tick();

    // ---------------- simultaneous read + write, 300 words each ----------------
    rd0 = rd_done_cnt;
    wr0 = wr_done_cnt;
    push(1'b0, 14'h2000, 9'd256);
    push(1'b1, 14'h3000, 9'd256);
    push(1'b0, 14'h2400, 9'd44);
    push(1'b1, 14'h3400, 9'd44);
    rd_base = 14'h2000; rd_total = 20'd300; rd_req = 1'b1;
    wr_base = 14'h3000; wr_total = 20'd300; wr_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    check("rr_both_busy", 32'({rd_busy, wr_busy}), 32'd3);
    for (int i = 0; i < 4; i++) serve(4'd0);
    repeat (4) tick();
    check("rr_rd_done_once", 32'(rd_done_cnt - rd0), 32'd1);
    check("rr_wr_done_once", 32'(wr_done_cnt - wr0), 32'd1);
    check("rr_err", 32'({rd_err, wr_err}), 32'd0);
    check("rr_idle", 32'({rd_busy, wr_busy}), 32'd0);

    // ---------------- read 600 words from 0x1000 ----------------
    rd0 = rd_done_cnt;
    push(1'b0, 14'h1000, 9'd256);
    push(1'b0, 14'h1400, 9'd256);
    push(1'b0, 14'h1800, 9'd88);
    rd_base = 14'h1000; rd_total = 20'd600; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("rd600_busy", 32'(rd_busy), 32'd1);
    expect_burst();
    // Request while busy must leave the job untouched.
    rd_base = 14'h0000; rd_total = 20'd7; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    finish_burst(4'd0);
    repeat (2) tick();
    check("rd600_no_early_done", 32'(rd_done_cnt - rd0), 32'd0);
    serve(4'd0);
    repeat (2) tick();
    check("rd600_no_early_done2", 32'(rd_done_cnt - rd0), 32'd0);
    serve(4'd0);
    tick();
    check("rd600_done_pulse", 32'(rd_done), 32'd1);
    check("rd600_busy_clear", 32'(rd_busy), 32'd0);
    repeat (3) tick();
    check("rd600_done_once", 32'(rd_done_cnt - rd0), 32'd1);
    check("rd600_err", 32'(rd_err), 32'd0);

    // ---------------- zero-length read ----------------
    req0 = req_cnt;
    rd_base = 14'h0100; rd_total = 20'd0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("zero_done", 32'(rd_done), 32'd1);
    check("zero_busy", 32'(rd_busy), 32'd0);
    check("zero_err",  32'(rd_err),  32'd0);
    tick();
    check("zero_done_1cyc", 32'(rd_done), 32'd0);
    repeat (8) tick();
    check("zero_no_burst", 32'(req_cnt - req0), 32'd0);

    // ---------------- address wrap ----------------
    push(1'b0, 14'h3C00, 9'd256);
    push(1'b0, 14'h0000, 9'd256);
    rd_base = 14'h3C00; rd_total = 20'd512; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    serve(4'd0);
    serve(4'd0);
    tick();
    check("wrap_done", 32'(rd_done), 32'd1);

    // ---------------- write error on first burst ----------------
    repeat (3) tick();
    req0 = req_cnt;
    wr0  = wr_done_cnt;
    push(1'b1, 14'h0800, 9'd256);
    wr_base = 14'h0800; wr_total = 20'd512; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    serve(4'b0011);
    tick();
    check("err_done",  32'(wr_done), 32'd1);
    check("err_flag",  32'(wr_err),  32'd1);
    check("err_busy",  32'(wr_busy), 32'd0);
    // Request in the done cycle is dropped.
    wr_base = 14'h0200; wr_total = 20'd5; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("done_cycle_req_ignored", 32'(wr_busy), 32'd0);
    check("err_still_set", 32'(wr_err), 32'd1);
    repeat (10) tick();
    check("err_no_more_bursts", 32'(req_cnt - req0), 32'd1);
    check("err_done_once", 32'(wr_done_cnt - wr0), 32'd1);
    // Next accepted request clears the sticky error.
    wr_base = 14'h0000; wr_total = 20'd0; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("err_cleared", 32'(wr_err), 32'd0);
    check("err_clear_done", 32'(wr_done), 32'd1);
    repeat (2) tick();

    // ---------------- reset during a burst ----------------
    push(1'b1, 14'h1000, 9'd256);
    wr_base = 14'h1000; wr_total = 20'd512; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    expect_burst();
    rst = 1'b1;
    tick();
    check("abort_ddr_req",  32'(ddr_req),  32'd0);
    check("abort_ddr_mode", 32'(ddr_mode), 32'd0);
    check("abort_ddr_base", 32'(ddr_base), 32'd0);
    check("abort_ddr_len",  32'(ddr_len),  32'd0);
    check("abort_busy",     32'({rd_busy, wr_busy}), 32'd0);
    check("abort_done",     32'({rd_done, wr_done}), 32'd0);
    check("abort_err",      32'({rd_err, wr_err}),   32'd0);
    rst = 1'b0;
    req0 = req_cnt;
    wr0  = wr_done_cnt;
    ddr_done = 1'b1;
    tick();
    ddr_done = 1'b0;
    repeat (10) tick();
    check("late_done_no_req",  32'(req_cnt - req0), 32'd0);
    check("late_done_no_done", 32'(wr_done_cnt - wr0), 32'd0);
    check("late_done_idle",    32'(wr_busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
